// File: rtl/exu_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit: operand handshake, result handshake, flush and busy.
interface exu_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/exu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes, sign fixed up on entry to DONE.
// XLEN must be at least 8 and a power of two.
module exu_muldiv #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter bit EARLY_OUT = 1'b1
) (
  input logic        clk,
  input logic        rst,
  exu_muldiv_if.slave io
);

  localparam int              CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;

  // Latched operation context
  op_e              op_q;
  logic             neg_q;   // product / quotient sign
  logic             neg_r;   // remainder sign
  logic             dz_q;
  logic [XLEN-1:0]  mcand;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]  hi;      // upper product half / partial remainder
  logic [XLEN-1:0]  lo;      // multiplier bits / dividend-quotient bits

  logic accept;
  logic last_step;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  op_e             op_in;
  logic            sgn_a, sgn_b;
  logic            is_div, is_rem;
  logic            dz_in, ovf_in, early_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] early_res;

  // NOTE: every always_comb output gets a default or full assignment up front
  // so no path can infer a latch.
  always_comb begin
    op_in  = op_e'(io.in_op);
    is_div = io.in_op[2];
    is_rem = io.in_op[2] & io.in_op[1];
    sgn_a  = io.in_a[XLEN-1] & (op_in == OP_MULH || op_in == OP_MULHSU ||
                                op_in == OP_DIV  || op_in == OP_REM);
    sgn_b  = io.in_b[XLEN-1] & (op_in == OP_MULH || op_in == OP_DIV ||
                                op_in == OP_REM);
    mag_a  = sgn_a ? -io.in_a : io.in_a;
    mag_b  = sgn_b ? -io.in_b : io.in_b;

    dz_in    = is_div & (io.in_b == '0);
    ovf_in   = (op_in == OP_DIV || op_in == OP_REM) &
               (io.in_a == INT_MIN) & (&io.in_b);
    early_in = dz_in | ovf_in;

    // Divide by zero wins over overflow (b cannot be both 0 and -1)
    if (dz_in) early_res = is_rem ? io.in_a : '1;
    else       early_res = is_rem ? '0      : io.in_a;
  end

  // ---------------------------------------------------------------------
  // Handshake and FSM
  // ---------------------------------------------------------------------
  assign io.in_ready  = (state == IDLE) & ~io.flush;
  assign io.out_valid = (state == DONE);
  assign io.busy      = (state != IDLE);
  assign accept       = io.in_valid & io.in_ready;
  assign last_step    = (state == CALC) & (cnt == CNT_ONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (EARLY_OUT && early_in) ? DONE : CALC;
      CALC:    if (cnt == CNT_ONE) state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (io.flush) state_nxt = IDLE;
  end

  // ---------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] hi_step, lo_step;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_sh  = {hi, lo[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, mcand});
    if (op_q[2]) begin
      // Difference is below the divisor, so the dropped top bit is always 0
      hi_step = div_ge ? (div_sh[XLEN-1:0] - mcand) : div_sh[XLEN-1:0];
      lo_step = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // ---------------------------------------------------------------------
  // Sign fix-up and result select from the final step
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, final_res;

  always_comb begin
    prod      = {hi_step, lo_step};
    prod_s    = neg_q ? -prod : prod;
    quot_s    = neg_q ? -lo_step : lo_step;
    rem_s     = neg_r ? -hi_step : hi_step;
    final_res = rem_s;
    case (op_q)
      OP_MUL:                       final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = dz_q ? '1 : quot_s;
      default:                      final_res = rem_s;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control and architecturally visible registers
  // ---------------------------------------------------------------------
  // NOTE: non-blocking assignments in clocked blocks so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      io.out_result <= '0;
      io.out_tag    <= '0;
    end else begin
      state <= state_nxt;

      if (io.flush)            cnt <= '0;
      else if (accept)         cnt <= CNT_LOAD;
      else if (state == CALC)  cnt <= cnt - CNT_ONE;

      if (accept) begin
        io.out_tag <= io.in_tag;
        if (EARLY_OUT && early_in) io.out_result <= early_res;
      end else if (last_step) begin
        io.out_result <= final_res;
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on
  // accept before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= op_in;
      neg_q <= sgn_a ^ sgn_b;
      neg_r <= sgn_a;
      dz_q  <= dz_in;
      hi    <= '0;
      if (is_div) begin
        lo    <= mag_a;
        mcand <= mag_b;
      end else begin
        lo    <= mag_b;
        mcand <= mag_a;
      end
    end else if (state == CALC) begin
      hi <= hi_step;
      lo <= lo_step;
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed bench for exu_muldiv (XLEN=32, EARLY_OUT=1): arithmetic results,
// latency, early-outs, backpressure, flush and asynchronous reset.
module tb_exu_muldiv;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  exu_muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) io ();

  exu_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W), .EARLY_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request for one edge, then scramble the inputs
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_op    = op;
    io.in_a     = a;
    io.in_b     = b;
    io.in_tag   = tag;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.in_op    = op ^ 3'd1;
    io.in_a     = ~a;
    io.in_b     = ~b;
    io.in_tag   = ~tag;
  endtask

  // Called #1 after the accept edge; lat = cycles from accept to out_valid
  task automatic wait_valid(output int lat);
    lat = 1;
    while (io.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       output logic [31:0] res, output logic [4:0] tg,
                       output int lat);
    issue(op, a, b, tag);
    wait_valid(lat);
    res = io.out_result;
    tg  = io.out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    io.in_valid  = 1'b0;
    io.flush     = 1'b0;
    io.out_ready = 1'b1;
    io.in_op     = 3'd0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.in_tag    = '0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (io.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", io.in_ready);
    end
    tests_run++;
    if (io.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b expected 0", io.out_valid);
    end
    tests_run++;
    if (io.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b expected 0", io.busy);
    end
    tests_run++;
    if (io.out_result !== 32'h0 || io.out_tag !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got result %h tag %0d expected 0/0",
               io.out_result, io.out_tag);
    end
  endtask

  task automatic test_mul();
    vec_t v[6];
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    v[0] = '{MUL,    32'h00000007, 32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB};
    v[1] = '{MULH,   32'h00000007, 32'hFFFFFFFD, 5'd10, 32'hFFFFFFFF};
    v[2] = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFE};
    v[3] = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFF};
    v[4] = '{MULH,   32'h80000000, 32'h80000000, 5'd13, 32'h40000000};
    v[5] = '{MUL,    32'h12345678, 32'h00000010, 5'd14, 32'h23456780};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].tag, res, tg, lat);
      tests_run++;
      if (res !== v[i].exp || tg !== v[i].tag || lat != 33) begin
        tests_failed++;
        $display("FAIL mul[%0d]: got %h tag %0d lat %0d expected %h tag %0d lat 33",
                 i, res, tg, lat, v[i].exp, v[i].tag);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[7];
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    v[0] = '{DIV,  32'hFFFFFFEC, 32'h00000003, 5'd1, 32'hFFFFFFFA};
    v[1] = '{REM,  32'hFFFFFFEC, 32'h00000003, 5'd2, 32'hFFFFFFFE};
    v[2] = '{DIVU, 32'h80000000, 32'h00000002, 5'd3, 32'h40000000};
    v[3] = '{REMU, 32'h00000064, 32'h00000007, 5'd4, 32'h00000002};
    v[4] = '{DIV,  32'h00000014, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFFA};
    v[5] = '{REM,  32'h00000014, 32'hFFFFFFFD, 5'd6, 32'h00000002};
    v[6] = '{DIVU, 32'hFFFFFFFF, 32'h00000001, 5'd7, 32'hFFFFFFFF};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].tag, res, tg, lat);
      tests_run++;
      if (res !== v[i].exp || tg !== v[i].tag || lat != 33) begin
        tests_failed++;
        $display("FAIL div[%0d]: got %h tag %0d lat %0d expected %h tag %0d lat 33",
                 i, res, tg, lat, v[i].exp, v[i].tag);
      end
    end
  endtask

  task automatic test_early();
    vec_t v[5];
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    v[0] = '{DIV,  32'h00000005, 32'h00000000, 5'd17, 32'hFFFFFFFF};
    v[1] = '{REMU, 32'h00000005, 32'h00000000, 5'd18, 32'h00000005};
    v[2] = '{DIV,  32'hFFFFFFFB, 32'h00000000, 5'd19, 32'hFFFFFFFF};
    v[3] = '{DIV,  32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h80000000};
    v[4] = '{REM,  32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h00000000};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].tag, res, tg, lat);
      tests_run++;
      if (res !== v[i].exp || tg !== v[i].tag || lat != 1) begin
        tests_failed++;
        $display("FAIL early[%0d]: got %h tag %0d lat %0d expected %h tag %0d lat 1",
                 i, res, tg, lat, v[i].exp, v[i].tag);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    io.out_ready = 1'b0;
    issue(MUL, 32'h00000007, 32'hFFFFFFFD, 5'd3);
    wait_valid(lat);
    tests_run++;
    if (lat != 33) begin
      tests_failed++;
      $display("FAIL bp_latency: got %0d expected 33", lat);
    end
    // Hold a competing request during the stall
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_op    = DIVU;
    io.in_a     = 32'd100;
    io.in_b     = 32'd7;
    io.in_tag   = 5'd22;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 || io.busy !== 1'b1 ||
          io.out_result !== 32'hFFFFFFEB || io.out_tag !== 5'd3) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got v%b r%b b%b %h tag %0d expected v1 r0 b1 ffffffeb tag 3",
                 c, io.out_valid, io.in_ready, io.busy, io.out_result, io.out_tag);
      end
    end
    @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 || io.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: got v%b r%b b%b expected v0 r1 b0",
               io.out_valid, io.in_ready, io.busy);
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    tests_run++;
    if (io.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_next_accept: got busy %b expected 1", io.busy);
    end
    wait_valid(lat);
    tests_run++;
    if (io.out_result !== 32'd14 || io.out_tag !== 5'd22 || lat != 33) begin
      tests_failed++;
      $display("FAIL bp_next_result: got %h tag %0d lat %0d expected 0000000e tag 22 lat 33",
               io.out_result, io.out_tag, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    int seen = 0;
    int lat;
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23);
    repeat (11) begin
      @(posedge clk);
      #1;
      if (io.out_valid === 1'b1) seen++;
    end
    // Twelfth CALC cycle: flush with a request alongside
    @(negedge clk);
    io.flush    = 1'b1;
    io.in_valid = 1'b1;
    io.in_op    = DIVU;
    io.in_a     = 32'd100;
    io.in_b     = 32'd7;
    io.in_tag   = 5'd24;
    @(posedge clk);
    #1;
    tests_run++;
    if (io.busy !== 1'b0 || io.out_valid !== 1'b0 || seen != 0) begin
      tests_failed++;
      $display("FAIL flush_abort: got busy %b out_valid %b seen %0d expected 0/0/0",
               io.busy, io.out_valid, seen);
    end
    tests_run++;
    if (io.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_in_ready: got %b expected 0", io.in_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (io.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_accept: got busy %b expected 0", io.busy);
    end
    @(negedge clk);
    io.flush = 1'b0;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    tests_run++;
    if (io.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_accept_after: got busy %b expected 1", io.busy);
    end
    wait_valid(lat);
    tests_run++;
    if (io.out_result !== 32'd14 || io.out_tag !== 5'd24 || lat != 33) begin
      tests_failed++;
      $display("FAIL flush_next_result: got %h tag %0d lat %0d expected 0000000e tag 24 lat 33",
               io.out_result, io.out_tag, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    issue(DIV, 32'hFFFFFFEC, 32'h00000003, 5'd25);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if (io.out_valid !== 1'b0 || io.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_state: got out_valid %b busy %b expected 0/0",
               io.out_valid, io.busy);
    end
    tests_run++;
    if (io.out_result !== 32'h0 || io.out_tag !== 5'd0) begin
      tests_failed++;
      $display("FAIL areset_outputs: got %h tag %0d expected 0 tag 0",
               io.out_result, io.out_tag);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (io.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_in_ready: got %b expected 1", io.in_ready);
    end
    do_op(MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd26, res, tg, lat);
    tests_run++;
    if (res !== 32'hFFFFFFFF || tg !== 5'd26 || lat != 33) begin
      tests_failed++;
      $display("FAIL areset_mulhsu: got %h tag %0d lat %0d expected ffffffff tag 26 lat 33",
               res, tg, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_early();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
